// File: rtl/sd_mod_mc_pkg.sv
// sd_pkg: shared definitions for the multi-channel sigma-delta modulator.
//
// Contents:
//   acc_t        - wide signed container used for all loop arithmetic, so
//                  sums never wrap before they are saturated
//   aw_of()      - integrator i1 / feedback width for a given sample width
//   aw2_of()     - integrator i2 width for a given sample width
//   sat()        - signed clamp to a given bit width, reports if it clamped
//   chan_state_t - per-channel loop state (i1, i2, sdo)
package sd_pkg;

    localparam int STATE_W = 64;

    typedef logic signed [STATE_W-1:0] acc_t;

    // i1 and the feedback term need two guard bits over the sample width
    function automatic int aw_of(input int width);
        return width + 2;
    endfunction

    // i2 accumulates i1, so it gets two more guard bits on top of that
    function automatic int aw2_of(input int width);
        return width + 4;
    endfunction

    // Clamp a full-width value into the signed range of 'bits' bits.
    // 'clamped' tells the caller whether the value had to be limited.
    function automatic acc_t sat(input acc_t value, input int bits, output logic clamped);
        acc_t hi;
        acc_t lo;
        acc_t result;
        hi      = (acc_t'(1) <<< (bits - 1)) - acc_t'(1);
        lo      = -(acc_t'(1) <<< (bits - 1));
        result  = value;
        clamped = 1'b0;
        if (value > hi) begin
            result  = hi;
            clamped = 1'b1;
        end else if (value < lo) begin
            result  = lo;
            clamped = 1'b1;
        end
        return result;
    endfunction

    typedef struct packed {
        acc_t i1;
        acc_t i2;
        logic sdo;
    } chan_state_t;

endpackage

// File: rtl/sd_mod_mc_chan.sv
// sd_chan: one channel of the sigma-delta modulator.
//
// Holds the input sample register, the first- or second-order loop and the
// sticky overload flag. The loop only advances on 'tick'; the sample register
// only changes on 'load'.
//
// Ports:
//   clock    in   single clock, posedge
//   sclr     in   synchronous active-high reset
//   tick     in   advance the loop by one modulator bit
//   load     in   capture v into the sample register
//   ovf_clr  in   clear the sticky overload flag
//   v        in   signed sample, WIDTH bits
//   sdo      out  registered 1-bit density stream
//   ovf      out  sticky integrator-saturation flag
module sd_chan
    import sd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ORDER = 1,
    parameter int VREF  = (1 << (WIDTH - 1)) - 1
) (
    input  logic             clock,
    input  logic             sclr,
    input  logic             tick,
    input  logic             load,
    input  logic             ovf_clr,
    input  logic [WIDTH-1:0] v,
    output logic             sdo,
    output logic             ovf
);

    localparam int AW   = aw_of(WIDTH);
    localparam int AW2  = aw2_of(WIDTH);
    localparam bit USE2 = (ORDER == 2);

    logic signed [WIDTH-1:0] x;
    chan_state_t             st;
    chan_state_t             st_next;
    logic                    clamp_next;

    // Next loop state for the coming tick. The second integrator is fed with
    // the already-updated i1 (CIFB structure); with a first-order loop i2 is
    // held at zero and its clamp is ignored.
    always_comb begin
        acc_t fb;
        acc_t r1;
        acc_t r2;
        logic c1;
        logic c2;
        fb = st.sdo ? acc_t'(VREF) : -acc_t'(VREF);
        r1 = sat(st.i1 + acc_t'(x) - fb, AW, c1);
        r2 = sat(st.i2 + r1 - fb, AW2, c2);
        st_next     = st;
        st_next.i1  = r1;
        st_next.i2  = USE2 ? r2 : '0;
        st_next.sdo = USE2 ? ~r2[STATE_W-1] : ~r1[STATE_W-1];
        clamp_next  = c1 | (c2 & USE2);
    end

    // Sample capture, loop update and overload flag. A tick in the same cycle
    // as a load still sees the old sample. A new clamp beats ovf_clr.
    always_ff @(posedge clock) begin
        if (sclr) begin
            x   <= '0;
            st  <= '0;
            ovf <= 1'b0;
        end else begin
            if (load) begin
                x <= v;
            end
            if (tick) begin
                st <= st_next;
            end
            if (tick && clamp_next) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    assign sdo = st.sdo;

endmodule

// File: rtl/sd_mod_mc.sv
// sd_mod_mc: multi-channel sigma-delta modulator.
//
// A shared clock divider produces one modulator bit every DIV clocks; every
// channel advances its loop on that tick and bit_stb marks the new sdo values.
//
// Ports:
//   clock    in   single clock, posedge
//   sclr     in   synchronous active-high reset
//   V        in   [NUM][WIDTH] signed samples, packed
//   load     in   capture all of V into the channel input registers
//   ovf_clr  in   clear all sticky overload flags
//   sdo      out  [NUM] registered bitstreams
//   bit_stb  out  one-cycle pulse marking new sdo values
//   ovf      out  [NUM] sticky integrator-saturation flags
module sd_mod_mc
    import sd_pkg::*;
#(
    parameter int NUM   = 16,
    parameter int WIDTH = 16,
    parameter int ORDER = 1,
    parameter int VREF  = (1 << (WIDTH - 1)) - 1,
    parameter int DIV   = 1
) (
    input  logic                      clock,
    input  logic                      sclr,
    input  logic [NUM-1:0][WIDTH-1:0] V,
    input  logic                      load,
    input  logic                      ovf_clr,
    output logic [NUM-1:0]            sdo,
    output logic                      bit_stb,
    output logic [NUM-1:0]            ovf
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    // Reject parameter sets the loop cannot support.
    generate
        if (ORDER != 1 && ORDER != 2) begin : g_bad_order
            $error("sd_mod_mc: ORDER must be 1 or 2");
        end
        if (NUM < 1 || DIV < 1) begin : g_bad_size
            $error("sd_mod_mc: NUM and DIV must be at least 1");
        end
        if (aw2_of(WIDTH) > STATE_W) begin : g_bad_width
            $error("sd_mod_mc: WIDTH too large for the loop arithmetic");
        end
    endgenerate

    logic [CW-1:0] cnt;
    logic          tick;

    // With DIV=1 the counter never leaves zero, so tick is high every cycle.
    assign tick = (cnt == LAST);

    // Bit-rate divider; bit_stb lands in the cycle right after each tick edge,
    // which is exactly when the channels present their new sdo.
    always_ff @(posedge clock) begin
        if (sclr) begin
            cnt     <= '0;
            bit_stb <= 1'b0;
        end else begin
            bit_stb <= tick;
            cnt     <= tick ? '0 : cnt + CW'(1);
        end
    end

    for (genvar g = 0; g < NUM; g++) begin : g_chan
        sd_chan #(
            .WIDTH (WIDTH),
            .ORDER (ORDER),
            .VREF  (VREF)
        ) u_chan (
            .clock   (clock),
            .sclr    (sclr),
            .tick    (tick),
            .load    (load),
            .ovf_clr (ovf_clr),
            .v       (V[g]),
            .sdo     (sdo[g]),
            .ovf     (ovf[g])
        );
    end

endmodule

// File: tb/tb_sd_mod_mc.sv
// tb_sd_mod_mc: self-checking bench for sd_mod_mc.
//
// Two instances share the inputs: dut_a is first order with DIV=1, dut_b is
// second order with DIV=4. A behavioural model of both follows every clock
// edge, and each scenario task compares the DUT outputs against it, alongside
// density, strobe-timing and overload checks derived from the modulator's
// rules.
module tb_sd_mod_mc;

    localparam int NUM   = 4;
    localparam int WIDTH = 16;
    localparam int VREF  = 32767;
    localparam int DIV_A = 1;
    localparam int DIV_B = 4;
    localparam int VW    = 4 * NUM + 2;
    localparam longint LIM1 = 64'sd1 <<< (WIDTH + 1);
    localparam longint LIM2 = 64'sd1 <<< (WIDTH + 3);

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                      sclr;
    logic                      load;
    logic                      ovf_clr;
    logic [NUM-1:0][WIDTH-1:0] V;
    logic [NUM-1:0]            sdo_a, ovf_a, sdo_b, ovf_b;
    logic                      stb_a, stb_b;
    logic [VW-1:0]             got_vec;

    int checks = 0;
    int errors = 0;

    assign got_vec = {sdo_a, ovf_a, stb_a, sdo_b, ovf_b, stb_b};

    sd_mod_mc #(.NUM(NUM), .WIDTH(WIDTH), .ORDER(1), .VREF(VREF), .DIV(DIV_A)) dut_a (
        .clock(clock), .sclr(sclr), .V(V), .load(load), .ovf_clr(ovf_clr),
        .sdo(sdo_a), .bit_stb(stb_a), .ovf(ovf_a)
    );

    sd_mod_mc #(.NUM(NUM), .WIDTH(WIDTH), .ORDER(2), .VREF(VREF), .DIV(DIV_B)) dut_b (
        .clock(clock), .sclr(sclr), .V(V), .load(load), .ovf_clr(ovf_clr),
        .sdo(sdo_b), .bit_stb(stb_b), .ovf(ovf_b)
    );

    // Reference model: index 0 mirrors dut_a, index 1 mirrors dut_b
    longint mx  [2][NUM];
    longint mi1 [2][NUM];
    longint mi2 [2][NUM];
    bit     msdo[2][NUM];
    bit     movf[2][NUM];
    int     mcnt[2];
    bit     mstb[2];

    function automatic longint clampv(input longint val, input longint lim, output bit hit);
        hit = 1'b0;
        if (val > lim - 1) begin
            hit = 1'b1;
            return lim - 1;
        end
        if (val < -lim) begin
            hit = 1'b1;
            return -lim;
        end
        return val;
    endfunction

    task automatic model_edge();
        int     div;
        bit     tick;
        bit     h1;
        bit     h2;
        longint fb;
        longint a;
        longint b;
        for (int d = 0; d < 2; d++) begin
            div = (d == 0) ? DIV_A : DIV_B;
            if (sclr) begin
                mcnt[d] = 0;
                mstb[d] = 1'b0;
                for (int ch = 0; ch < NUM; ch++) begin
                    mx[d][ch] = 0; mi1[d][ch] = 0; mi2[d][ch] = 0;
                    msdo[d][ch] = 1'b0; movf[d][ch] = 1'b0;
                end
            end else begin
                tick = (mcnt[d] == div - 1);
                for (int ch = 0; ch < NUM; ch++) begin
                    h1 = 1'b0;
                    h2 = 1'b0;
                    if (tick) begin
                        fb = msdo[d][ch] ? VREF : -VREF;
                        a  = clampv(mi1[d][ch] + mx[d][ch] - fb, LIM1, h1);
                        if (d == 1) begin
                            b = clampv(mi2[d][ch] + a - fb, LIM2, h2);
                            mi2[d][ch]  = b;
                            msdo[d][ch] = (b >= 0);
                        end else begin
                            msdo[d][ch] = (a >= 0);
                        end
                        mi1[d][ch] = a;
                    end
                    if (h1 || h2)
                        movf[d][ch] = 1'b1;
                    else if (ovf_clr)
                        movf[d][ch] = 1'b0;
                    if (load)
                        mx[d][ch] = longint'($signed(V[ch]));
                end
                mstb[d] = tick;
                mcnt[d] = tick ? 0 : mcnt[d] + 1;
            end
        end
    endtask

    always @(posedge clock) model_edge();

    function automatic logic [VW-1:0] exp_vec();
        logic [NUM-1:0] sa, oa, sb, ob;
        for (int ch = 0; ch < NUM; ch++) begin
            sa[ch] = msdo[0][ch]; oa[ch] = movf[0][ch];
            sb[ch] = msdo[1][ch]; ob[ch] = movf[1][ch];
        end
        return {sa, oa, mstb[0], sb, ob, mstb[1]};
    endfunction

    function automatic logic [WIDTH-1:0] rand_sample();
        int r;
        r = int'($urandom_range(0, 2 * VREF)) - VREF;
        return WIDTH'(r);
    endfunction

    // Reset state straight after power-up
    task automatic test_reset();
        sclr = 1'b1; load = 1'b0; ovf_clr = 1'b0;
        for (int ch = 0; ch < NUM; ch++) V[ch] = rand_sample();
        repeat (3) @(negedge clock);
        checks++;
        if (got_vec !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", got_vec, {VW{1'b0}});
        end
        checks++;
        if (got_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL reset_model: got %h expected %h", got_vec, exp_vec());
        end
    endtask

    // First-order loop with a zero input: 1,1,0,1,0,... then 50% density
    task automatic test_idle_pattern();
        bit pat[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        int ones = 0;
        sclr = 1'b0; load = 1'b1; V = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            load = 1'b0;
            checks++;
            if (sdo_a[0] !== pat[k]) begin
                errors++;
                $display("[TB] FAIL idle_seq bit %0d: got %b expected %b", k, sdo_a[0], pat[k]);
            end
        end
        for (int c = 0; c < 1024; c++) begin
            @(negedge clock);
            checks++;
            if (got_vec !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL idle_model cycle %0d: got %h expected %h", c, got_vec, exp_vec());
            end
            ones += int'(sdo_a[0]);
        end
        checks++;
        if (ones < 511 || ones > 513) begin
            errors++;
            $display("[TB] FAIL idle_density: got %0d ones expected 512+-1", ones);
        end
        checks++;
        if (ovf_a !== '0) begin
            errors++;
            $display("[TB] FAIL idle_ovf: got %b expected 0", ovf_a);
        end
    endtask

    // First-order DC inputs, channels independent: +0.5 FS -> 75%, -0.5 FS -> 25%
    task automatic test_dc_order1();
        int ones0 = 0;
        int ones1 = 0;
        sclr = 1'b1;
        @(negedge clock);
        sclr = 1'b0; load = 1'b1;
        V[0] = WIDTH'(16384); V[1] = WIDTH'(-16384); V[2] = '0; V[3] = rand_sample();
        @(negedge clock);
        load = 1'b0;
        for (int c = 0; c < 1024; c++) begin
            @(negedge clock);
            checks++;
            if (got_vec !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL dc1_model cycle %0d: got %h expected %h", c, got_vec, exp_vec());
            end
            ones0 += int'(sdo_a[0]);
            ones1 += int'(sdo_a[1]);
        end
        checks++;
        if (ones0 < 766 || ones0 > 770) begin
            errors++;
            $display("[TB] FAIL dc1_pos_density: got %0d ones expected 768+-2", ones0);
        end
        checks++;
        if (ones1 < 254 || ones1 > 258) begin
            errors++;
            $display("[TB] FAIL dc1_neg_density: got %0d ones expected 256+-2", ones1);
        end
    endtask

    // Second-order loop at DIV=4: strobe spacing, sdo stable between strobes, density
    task automatic test_order2_div4();
        int strobes = 0;
        int ones    = 0;
        int last    = -1;
        logic [NUM-1:0] prev_sdo;
        sclr = 1'b1;
        @(negedge clock);
        sclr = 1'b0; load = 1'b1;
        for (int ch = 0; ch < NUM; ch++) V[ch] = WIDTH'(8192);
        @(negedge clock);
        load = 1'b0;
        prev_sdo = sdo_b;
        for (int c = 0; c < 4096 * DIV_B + 16 && strobes < 4096; c++) begin
            @(negedge clock);
            checks++;
            if (got_vec !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL div4_model cycle %0d: got %h expected %h", c, got_vec, exp_vec());
            end
            checks++;
            if (sdo_b !== prev_sdo && stb_b !== 1'b1) begin
                errors++;
                $display("[TB] FAIL div4_sdo_hold cycle %0d: got %b expected %b", c, sdo_b, prev_sdo);
            end
            prev_sdo = sdo_b;
            if (stb_b === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (c - last != DIV_B) begin
                        errors++;
                        $display("[TB] FAIL div4_strobe_gap: got %0d expected %0d", c - last, DIV_B);
                    end
                end
                last = c;
                strobes++;
                ones += int'(sdo_b[0]);
            end
        end
        checks++;
        if (strobes != 4096) begin
            errors++;
            $display("[TB] FAIL div4_strobe_count: got %0d expected 4096", strobes);
        end
        checks++;
        if (ones < 2556 || ones > 2564) begin
            errors++;
            $display("[TB] FAIL div4_density: got %0d ones expected 2560+-4", ones);
        end
        checks++;
        if (ovf_b !== '0) begin
            errors++;
            $display("[TB] FAIL div4_ovf: got %b expected 0", ovf_b);
        end
    endtask

    // Full-scale input into the second-order loop saturates i2
    task automatic test_overload();
        int waited = 0;
        sclr = 1'b1;
        @(negedge clock);
        sclr = 1'b0; load = 1'b1; V = '0; V[0] = WIDTH'(VREF);
        @(negedge clock);
        load = 1'b0;
        while (ovf_b[0] !== 1'b1 && waited < 400) begin
            @(negedge clock);
            waited++;
            checks++;
            if (got_vec !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL ovf_model cycle %0d: got %h expected %h", waited, got_vec, exp_vec());
            end
        end
        checks++;
        if (ovf_b[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_set: got %b expected 1 within 400 cycles", ovf_b[0]);
        end
        checks++;
        if (ovf_b[NUM-1:1] !== '0) begin
            errors++;
            $display("[TB] FAIL ovf_other_channels: got %b expected 0", ovf_b[NUM-1:1]);
        end
        // clear request in a tick cycle that clamps again: set wins
        waited = 0;
        while (mcnt[1] != DIV_B - 1 && waited < 8) begin
            @(negedge clock);
            waited++;
        end
        ovf_clr = 1'b1;
        @(negedge clock);
        ovf_clr = 1'b0;
        checks++;
        if (ovf_b[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_clr_vs_clamp: got %b expected 1", ovf_b[0]);
        end
        // input back to zero, clear in a non-tick cycle
        V[0] = '0; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        waited = 0;
        while (mcnt[1] != 0 && waited < 8) begin
            @(negedge clock);
            waited++;
        end
        ovf_clr = 1'b1;
        @(negedge clock);
        ovf_clr = 1'b0;
        checks++;
        if (ovf_b[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_clear: got %b expected 0", ovf_b[0]);
        end
        checks++;
        if (got_vec !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL ovf_clear_model: got %h expected %h", got_vec, exp_vec());
        end
    endtask

    // V wiggling without load must not change the bitstreams; load on a tick
    task automatic test_no_load();
        logic [NUM-1:0]            ref_a[64];
        logic [NUM-1:0]            ref_b[64];
        logic [NUM-1:0][WIDTH-1:0] held;
        for (int ch = 0; ch < NUM; ch++) held[ch] = WIDTH'(int'($urandom_range(0, 32000)) - 16000);
        for (int run = 0; run < 2; run++) begin
            sclr = 1'b1;
            @(negedge clock);
            sclr = 1'b0; load = 1'b1; V = held;
            @(negedge clock);
            load = 1'b0;
            for (int k = 0; k < 64; k++) begin
                if (run == 0)
                    for (int ch = 0; ch < NUM; ch++) V[ch] = rand_sample();
                @(negedge clock);
                checks++;
                if (got_vec !== exp_vec()) begin
                    errors++;
                    $display("[TB] FAIL noload_model run %0d cycle %0d: got %h expected %h", run, k, got_vec, exp_vec());
                end
                if (run == 0) begin
                    ref_a[k] = sdo_a;
                    ref_b[k] = sdo_b;
                end else begin
                    checks++;
                    if (sdo_a !== ref_a[k] || sdo_b !== ref_b[k]) begin
                        errors++;
                        $display("[TB] FAIL noload_stream cycle %0d: got %b/%b expected %b/%b", k, sdo_a, sdo_b, ref_a[k], ref_b[k]);
                    end
                end
            end
        end
        // load landing in a tick cycle of dut_b
        while (mcnt[1] != DIV_B - 1) @(negedge clock);
        for (int ch = 0; ch < NUM; ch++) V[ch] = rand_sample();
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            checks++;
            if (got_vec !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL load_on_tick cycle %0d: got %h expected %h", k, got_vec, exp_vec());
            end
        end
    endtask

    // Random samples, loads, clears and occasional resets
    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            @(negedge clock);
            checks++;
            if (got_vec !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL random_model cycle %0d: got %h expected %h", c, got_vec, exp_vec());
            end
            for (int ch = 0; ch < NUM; ch++) V[ch] = rand_sample();
            load    = ($urandom_range(0, 3) == 0);
            ovf_clr = ($urandom_range(0, 7) == 0);
            sclr    = ($urandom_range(0, 49) == 0);
        end
        sclr = 1'b0; load = 1'b0; ovf_clr = 1'b0;
    endtask

    // Reset mid-stream with load held high: everything back to zero, x too
    task automatic test_sclr_mid();
        bit pat[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        int first = -1;
        for (int ch = 0; ch < NUM; ch++) V[ch] = WIDTH'(16384);
        load = 1'b1; sclr = 1'b0;
        repeat (10) @(negedge clock);
        sclr = 1'b1;
        @(negedge clock);
        checks++;
        if (got_vec !== '0) begin
            errors++;
            $display("[TB] FAIL sclr_outputs: got %h expected %h", got_vec, {VW{1'b0}});
        end
        sclr = 1'b0; load = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            checks++;
            if (got_vec !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL sclr_model cycle %0d: got %h expected %h", k, got_vec, exp_vec());
            end
            if (k <= 5) begin
                checks++;
                if (sdo_a[0] !== pat[k-1]) begin
                    errors++;
                    $display("[TB] FAIL sclr_x_zero bit %0d: got %b expected %b", k - 1, sdo_a[0], pat[k-1]);
                end
            end
            if (stb_b === 1'b1 && first < 0) first = k;
        end
        checks++;
        if (first != DIV_B) begin
            errors++;
            $display("[TB] FAIL sclr_first_strobe: got cycle %0d expected %0d", first, DIV_B);
        end
    endtask

    initial begin
        sclr = 1'b1; load = 1'b0; ovf_clr = 1'b0; V = '0;
        $display("[TB] starting sd_mod_mc bench");
        test_reset();
        test_idle_pattern();
        test_dc_order1();
        test_order2_div4();
        test_overload();
        test_no_load();
        test_random();
        test_sclr_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
